// File: rtl/seq_multiplier32.sv
// rtl/seq_multiplier32.sv - iterative unsigned shift-and-add multiplier with start/busy/done handshake
// Optional MULT_ZERO_BYPASS_EN: zero operands finish one cycle after acceptance.
module seq_multiplier32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CW-1:0]     cnt;
    logic [2*WIDTH-1:0] product_q;

    logic              accept;
    logic              last;
    logic              zero_op;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  acc_hi_next;
    logic [WIDTH-1:0]  acc_lo_next;

    // One ripple-adder step: carry-out becomes the top bit of the shifted accumulator.
    assign sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign acc_hi_next = sum[WIDTH:1];
    assign acc_lo_next = {sum[0], acc_lo[WIDTH-1:1]};

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = zero_op ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
            if (zero_op) begin
                product_q <= '0;
            end
        end else if (state == RUN) begin
            acc_hi <= acc_hi_next;
            acc_lo <= acc_lo_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                product_q <= {acc_hi_next, acc_lo_next};
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier32.sv
// tb/tb_seq_multiplier32.sv - directed self-checking bench for seq_multiplier32
module tb_seq_multiplier32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks;
    int failures;
    int overlap_cnt;

    seq_multiplier32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap_cnt++;
    end

    // Issues one operation from idle; lat counts edges from accept (as 1) to the done cycle.
    task automatic do_mult(input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output int bcyc);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        bcyc = 0;
        @(negedge clk);
        while (!done && lat < 200) begin
            if (busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 64'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcyc;
        do_mult(32'd3, 32'd5, lat, bcyc);
        checks++; if (lat != 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        checks++; if (bcyc != 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=32", bcyc); end
        checks++; if (product !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL basic_product got=%h exp=f", product); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_carry;
        int lat, bcyc;
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
        checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL carry_product got=%h exp=fffffffe00000001", product); end
        checks++; if (lat != 33) begin failures++; $display("FAIL carry_latency got=%0d exp=33", lat); end
        do_mult(32'd1, 32'hFFFF_FFFF, lat, bcyc);
        checks++; if (product !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL one_product got=%h exp=ffffffff", product); end
    endtask

    task automatic test_ignore_start;
        int lat, bcyc, extra_done, extra_busy;
        @(negedge clk);
        a = 32'h8000_0000; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'd7; b = 32'd7;
        lat = 1; bcyc = 0;
        @(negedge clk);
        while (!done && lat < 200) begin
            if (busy) bcyc++;
            start = (bcyc == 10);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if (!done || lat != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        checks++; if (product !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL ignore_product got=%h exp=100000000", product); end
        extra_done = 0; extra_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++; if (extra_done != 0 || extra_busy != 0) begin failures++; $display("FAIL ignore_no_second_op got done=%0d busy=%0d exp 0 0", extra_done, extra_busy); end
        checks++; if (product !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL ignore_product_held got=%h exp=100000000", product); end
    endtask

    task automatic test_reset_mid;
        int lat, bcyc, cyc, extra_done, extra_busy;
        @(negedge clk);
        a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcyc = 0; cyc = 0;
        @(negedge clk);
        while (bcyc < 15 && cyc < 100) begin
            if (busy) bcyc++;
            if (bcyc < 15) @(negedge clk);
            cyc++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (product !== 64'h0) begin failures++; $display("FAIL midrst_product got=%h exp=0", product); end
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0; extra_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++; if (extra_done != 0 || extra_busy != 0) begin failures++; $display("FAIL midrst_quiet got done=%0d busy=%0d exp 0 0", extra_done, extra_busy); end
        do_mult(32'd9, 32'd11, lat, bcyc);
        checks++; if (product !== 64'd99 || lat != 33) begin failures++; $display("FAIL midrst_recover got prod=%0d lat=%0d exp 99 33", product, lat); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd6; b = 32'd7;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (!done || product !== 64'd6) begin failures++; $display("FAIL b2b_first got done=%b prod=%0d exp 1 6", done, product); end
        n = 0;
        @(negedge clk);
        n++;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++; if (n != 33) begin failures++; $display("FAIL b2b_spacing got=%0d exp=33", n); end
        checks++; if (product !== 64'd42) begin failures++; $display("FAIL b2b_second_product got=%0d exp=42", product); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_zero;
        int lat, bcyc, exp_lat, exp_busy;
`ifdef MULT_ZERO_BYPASS_EN
        exp_lat = 1; exp_busy = 0;
`else
        exp_lat = 33; exp_busy = 32;
`endif
        do_mult(32'd0, 32'd123, lat, bcyc);
        checks++; if (product !== 64'h0) begin failures++; $display("FAIL zero_product got=%h exp=0", product); end
        checks++; if (lat != exp_lat) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat); end
        checks++; if (bcyc != exp_busy) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bcyc, exp_busy); end
    endtask

    task automatic test_exclusive;
        checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL busy_done_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        overlap_cnt = 0;
        test_reset;
        test_basic;
        test_carry;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_zero;
        test_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier32.md
# seq_multiplier32

Iterative unsigned 32×32→64 shift-and-add multiplier that sits directly downstream of the lab's 32-bit ripple adder. Each cycle it consumes one add result (sum plus carry-out) of the running partial product and the multiplicand, then shifts. It gives the ALU a multi-cycle multiply with a start/busy/done handshake. Product width is double the operand width, so no overflow condition exists.

## Interface
- WIDTH, 32, operand width; product is 2×WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  multiplicand, captured on accepted start
- b  input  WIDTH  multiplier, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when product is valid
- product  output  2×WIDTH  registered result, held until next completion

One clock; reset is asynchronous and active-low.

## Operation
- Internal state:
  - mcand[WIDTH-1:0]
  - acc_hi[WIDTH-1:0]
  - acc_lo[WIDTH-1:0], which initially holds the multiplier
  - cnt[$clog2(WIDTH):0]
  - FSM with states IDLE, RUN, DONE
- IDLE: busy=0, done=0. An edge with start=1 performs the following, then goes to RUN:
  - mcand←a
  - acc_lo←b
  - acc_hi←0
  - cnt←0
- RUN, once per edge:
  - {c,s} = acc_hi + (acc_lo[0] ? mcand : 0). This is a (WIDTH+1)-bit sum, so the carry is kept.
  - {acc_hi,acc_lo} ← {c,s,acc_lo} >> 1, a logical shift right of the 2×WIDTH+1-bit value.
  - cnt←cnt+1.
  - On the iteration where cnt==WIDTH-1, also load product←{new acc_hi, new acc_lo} and go to DONE.
- DONE: done=1, busy=0, lasts exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (operands captured, next state RUN).
  - Otherwise the next state is IDLE.
- start while in RUN is ignored, and operands are not re-sampled.
- a and b may change freely after acceptance.
- product changes only on the completing edge. It is never exposed mid-computation.
- Arithmetic is unsigned modulo 2^(2×WIDTH), which is always exact.

## Timing
- Reset values (asynchronous, take effect immediately on rst_n=0):
  - state=IDLE
  - busy=0, done=0, product=0
  - all internal registers 0
- rst_n asserted mid-RUN aborts the operation. No done pulse follows. product returns to 0.
- Accept edge E0: busy rises after E0.
- Iterations occur on edges E1..EWIDTH. product is updated on EWIDTH.
- After EWIDTH: busy=0 and done=1 for one cycle. Latency is WIDTH+1 edges from accept to done (33 for WIDTH=32).
- Back-to-back: start held high during the DONE cycle gives a throughput of one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.

## Configuration
- MULT_ZERO_BYPASS_EN:
  - Defined: at the accept edge, if a==0 or b==0, skip RUN. The FSM goes straight to DONE with product←0, so done pulses in the cycle after acceptance (latency 1) and busy stays 0.
  - Undefined: zero operands take the full WIDTH+1 cycles like any other operands.
  - Results are identical either way; only latency differs.

## Test plan
- a=3, b=5, start for one cycle → done exactly 33 cycles after the accept edge; product=64'h0000_0000_0000_000F; busy high for 32 cycles.
- a=b=32'hFFFF_FFFF → product=64'hFFFF_FFFE_0000_0001. This exercises the carry-out on every iteration.
- a=32'h8000_0000, b=2 → product=64'h1_0000_0000. Then pulse start with a=7, b=7 at cycle 10 of busy → ignored; the first result is unchanged and no second done follows.
- rst_n=0 during cycle 15 of RUN → busy=0, done=0, product=0 immediately; no done pulse afterwards. A new start then completes normally.
- start held high across the DONE cycle with a=6, b=7 → second product=42 exactly 33 cycles after the first done.
- a=0, b=123:
  - MULT_ZERO_BYPASS_EN defined → done 1 cycle after accept, product=0.
  - Undefined → done after 33 cycles, product=0.
